regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// Two-port (JTAG host / test engine) arbiter in front of a NUM_REGS x 32 register file.
// Define REGFILE_ARB_HOST_PRIORITY_EN for fixed host priority; otherwise ties use round robin.
module regfile_arbiter #(
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 6
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    input  logic              test_req,
    input  logic              test_we,
    input  logic [ADDR_W-1:0] test_addr,
    input  logic [31:0]       test_wdata,
    output logic              host_gnt,
    output logic              test_gnt,
    output logic              host_rvalid,
    output logic              test_rvalid,
    output logic [31:0]       host_rdata,
    output logic [31:0]       test_rdata,
    output logic              addr_err,
    output logic [15:0]       host_cnt,
    output logic [15:0]       test_cnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    state_t            state;
    logic [31:0]       regs [NUM_REGS];
    logic              sel_test;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              last_test;

    logic              pick_test;
    logic [ADDR_W-1:0] pick_addr;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NUM_REGS_W;
    endfunction

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        pick_test = test_req;
        if (host_req && test_req) begin
`ifdef REGFILE_ARB_HOST_PRIORITY_EN
            pick_test = 1'b0;
`else
            pick_test = !last_test;
`endif
        end
        pick_addr = pick_test ? test_addr : host_addr;
    end

    // NOTE: the register file sits in the reset domain because reset must clear its contents.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            sel_test    <= 1'b0;
            sel_we      <= 1'b0;
            sel_addr    <= '0;
            sel_wdata   <= '0;
            last_test   <= 1'b1;
            host_gnt    <= 1'b0;
            test_gnt    <= 1'b0;
            host_rvalid <= 1'b0;
            test_rvalid <= 1'b0;
            host_rdata  <= '0;
            test_rdata  <= '0;
            addr_err    <= 1'b0;
            host_cnt    <= '0;
            test_cnt    <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            host_gnt    <= 1'b0;
            test_gnt    <= 1'b0;
            host_rvalid <= 1'b0;
            test_rvalid <= 1'b0;
            addr_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (host_req || test_req) begin
                        sel_test  <= pick_test;
                        sel_we    <= pick_test ? test_we : host_we;
                        sel_addr  <= pick_addr;
                        sel_wdata <= pick_test ? test_wdata : host_wdata;
                        host_gnt  <= !pick_test;
                        test_gnt  <= pick_test;
                        addr_err  <= !in_range(pick_addr);
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Commit point: write, bookkeeping and read capture all land on this edge.
                    if (sel_we && in_range(sel_addr)) regs[sel_addr] <= sel_wdata;
                    last_test <= sel_test;
                    if (sel_test) test_cnt <= test_cnt + 16'd1;
                    else          host_cnt <= host_cnt + 16'd1;
                    if (!sel_we) begin
                        if (sel_test) begin
                            test_rvalid <= 1'b1;
                            test_rdata  <= in_range(sel_addr) ? regs[sel_addr] : 32'h0;
                        end else begin
                            host_rvalid <= 1'b1;
                            host_rdata  <= in_range(sel_addr) ? regs[sel_addr] : 32'h0;
                        end
                    end
                    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed self-checking bench for regfile_arbiter; honours REGFILE_ARB_HOST_PRIORITY_EN.
module tb_regfile_arbiter;

    logic        clk = 1'b0;
    logic        areset;
    logic        host_req, test_req, host_we, test_we;
    logic [2:0]  host_addr, test_addr;
    logic [31:0] host_wdata, test_wdata;
    logic        host_gnt, test_gnt, host_rvalid, test_rvalid, addr_err;
    logic [31:0] host_rdata, test_rdata;
    logic [15:0] host_cnt, test_cnt;

    int tests  = 0;
    int failed = 0;

`ifdef REGFILE_ARB_HOST_PRIORITY_EN
    localparam bit HOST_PRIO = 1'b1;
`else
    localparam bit HOST_PRIO = 1'b0;
`endif

    regfile_arbiter #(.ADDR_W(3), .NUM_REGS(6)) dut (
        .clk(clk), .areset(areset),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .test_req(test_req), .test_we(test_we), .test_addr(test_addr), .test_wdata(test_wdata),
        .host_gnt(host_gnt), .test_gnt(test_gnt),
        .host_rvalid(host_rvalid), .test_rvalid(test_rvalid),
        .host_rdata(host_rdata), .test_rdata(test_rdata),
        .addr_err(addr_err), .host_cnt(host_cnt), .test_cnt(test_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction from IDLE: gnt one cycle after req, rvalid one cycle after gnt.
    task automatic access(input logic is_test, input logic we, input logic [2:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input string tag);
        if (is_test) begin
            test_req = 1'b1; test_we = we; test_addr = addr; test_wdata = wdata;
        end else begin
            host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
        end
        step();
        check({tag, "_gnt"},   is_test ? test_gnt : host_gnt, 32'd1);
        check({tag, "_ogn"},   is_test ? host_gnt : test_gnt, 32'd0);
        check({tag, "_err"},   addr_err, 32'(exp_err));
        host_req = 1'b0;
        test_req = 1'b0;
        step();
        check({tag, "_rv"},    is_test ? test_rvalid : host_rvalid, 32'(!we));
        check({tag, "_orv"},   is_test ? host_rvalid : test_rvalid, 32'd0);
        if (!we) check({tag, "_rd"}, is_test ? test_rdata : host_rdata, exp_rdata);
        step();
    endtask

    // Waits a bounded number of cycles for a grant; reports which port won (0 host, 1 test).
    task automatic wait_gnt(input string tag, output logic got_test);
        logic seen;
        seen     = 1'b0;
        got_test = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (host_gnt || test_gnt) begin
                seen     = 1'b1;
                got_test = test_gnt;
                check({tag, "_excl"}, 32'(host_gnt && test_gnt), 32'd0);
            end
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    logic [31:0] exp_regs [6];
    logic        who;

    initial begin
        areset = 1'b1;
        host_req = 1'b0; test_req = 1'b0; host_we = 1'b0; test_we = 1'b0;
        host_addr = '0; test_addr = '0; host_wdata = '0; test_wdata = '0;
        step(); step();
        check("rst_hgnt", host_gnt, 32'd0);
        check("rst_tgnt", test_gnt, 32'd0);
        check("rst_hrv",  host_rvalid, 32'd0);
        check("rst_trv",  test_rvalid, 32'd0);
        check("rst_err",  addr_err, 32'd0);
        check("rst_hrd",  host_rdata, 32'd0);
        check("rst_trd",  test_rdata, 32'd0);
        check("rst_hcnt", host_cnt, 32'd0);
        check("rst_tcnt", test_cnt, 32'd0);
        areset = 1'b0;
        step();

        // Basic write/read through both ports onto the shared file
        access(1'b0, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0,        1'b0, "h_wr2");
        access(1'b0, 1'b0, 3'd2, 32'h0,        32'hDEADBEEF, 1'b0, "h_rd2");
        access(1'b1, 1'b1, 3'd5, 32'hA5A50001, 32'h0,        1'b0, "t_wr5");
        access(1'b1, 1'b0, 3'd5, 32'h0,        32'hA5A50001, 1'b0, "t_rd5");
        access(1'b0, 1'b0, 3'd5, 32'h0,        32'hA5A50001, 1'b0, "h_rd5");

        // Out-of-range accesses
        access(1'b1, 1'b0, 3'd7, 32'h0,        32'h0,        1'b1, "t_rd7");
        access(1'b1, 1'b1, 3'd6, 32'hFFFFFFFF, 32'h0,        1'b1, "t_wr6");
        exp_regs = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'hA5A50001};
        for (int i = 0; i < 6; i++)
            access(1'b1, 1'b0, 3'(i), 32'h0, exp_regs[i], 1'b0, $sformatf("t_scan%0d", i));
        check("cnt_host", host_cnt, 32'd3);
        check("cnt_test", test_cnt, 32'd10);
        check("hold_hrd", host_rdata, 32'hA5A50001);

        // Both ports requesting together right after reset
        areset = 1'b1;
        step();
        areset = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 3'd0;
        test_req = 1'b1; test_we = 1'b0; test_addr = 3'd1;
        for (int g = 0; g < 4; g++) begin
            wait_gnt($sformatf("tie%0d", g), who);
            check($sformatf("tie%0d_who", g), 32'(who), HOST_PRIO ? 32'd0 : 32'(g % 2));
        end
        host_req = 1'b0;
        wait_gnt("tail", who);
        check("tail_who", 32'(who), 32'd1);
        test_req = 1'b0;
        step(); step();
        check("tie_hcnt", host_cnt, HOST_PRIO ? 32'd4 : 32'd2);
        check("tie_tcnt", test_cnt, HOST_PRIO ? 32'd1 : 32'd3);

        // Reset landing in the ACCESS cycle of a host write
        host_req = 1'b1; host_we = 1'b1; host_addr = 3'd1; host_wdata = 32'h12345678;
        step();
        areset   = 1'b1;
        host_req = 1'b0;
        #1;
        check("abort_gnt",  host_gnt, 32'd0);
        check("abort_hcnt", host_cnt, 32'd0);
        step();
        areset = 1'b0;
        step();
        check("abort_rv",   host_rvalid, 32'd0);
        access(1'b0, 1'b0, 3'd1, 32'h0, 32'h0, 1'b0, "abort_rd1");
        check("abort_cnt1", host_cnt, 32'd1);

        // Counter wrap: preset near the top instead of running 65536 transactions
        force dut.host_cnt = 16'hFFFE;
        #1;
        release dut.host_cnt;
        access(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, "wrap_a");
        check("wrap_ffff", host_cnt, 32'h0000FFFF);
        access(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, "wrap_b");
        check("wrap_zero", host_cnt, 32'h00000000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
